// File: rtl/ucode_dispatch_pkg.sv
// Shared decode definitions for microcode dispatch: program IDs, widths, FSM encoding.
package ucode_dispatch_pkg;

  localparam int unsigned PROG_W    = 4;
  localparam logic [3:0]  PROG_NONE = 4'd0;
  localparam logic [3:0]  INT_PROG  = 4'd6;

  // Exception-entry microcode programs known to decode.
  typedef enum logic [3:0] {
    EXC_PROG_GP = 4'd11,
    EXC_PROG_PF = 4'd12,
    EXC_PROG_MC = 4'd13
  } exc_prog_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ucode_pend_reg.sv
// Pending-request latch: valid bit plus payload, captured only when empty, clear dominates.
module ucode_pend_reg #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_set,
  input  logic [W-1:0] i_set_data,
  input  logic         i_clr,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_set && !r_valid) begin
      r_valid <= 1'b1;
      r_data  <= i_set_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ucode_dispatch.sv
// Arbitrates exception / interrupt / decoder microcode requests and owns the ROM
// program select until the last micro-op is accepted downstream.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | decoder owns the pipe; pending sources arbitrated each cycle
// ST_RUN  | microcode program r_cur_prog active until the done handshake
module ucode_dispatch #(
  parameter int unsigned             PROG_W   = ucode_dispatch_pkg::PROG_W,
  parameter logic [PROG_W-1:0]       INT_PROG = PROG_W'(ucode_dispatch_pkg::INT_PROG)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_dec_valid,
  input  logic              i_dec_ucode_req,
  input  logic [PROG_W-1:0] i_dec_ucode_prog,
  output logic              o_dec_ready,
  input  logic              i_exc_req,
  input  logic [PROG_W-1:0] i_exc_prog,
  input  logic              i_int_req,
  input  logic              i_eflags_if,
  input  logic              i_flush,
  input  logic              i_rom_ready,
  input  logic              i_s1_valid,
  input  logic              i_s1_ready,
  output logic              o_rom_in_control,
  output logic [PROG_W-1:0] o_rom_control,
  output logic              o_int_ack
);

  import ucode_dispatch_pkg::*;

  localparam logic [PROG_W-1:0] P_NONE = PROG_W'(PROG_NONE);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [PROG_W-1:0] r_cur_prog;
  logic [PROG_W-1:0] w_cur_prog_nxt;
  logic              r_int_ack;

  logic              w_exc_pend;
  logic [PROG_W-1:0] w_exc_pend_prog;
  logic              w_exc_set;
  logic              w_exc_clr;
  logic              w_flush_pend;
  logic [PROG_W-1:0] w_flush_unused_data;

  logic w_idle;
  logic w_run;
  logic w_int_live;
  logic w_done;
  logic w_dec_take;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_run      = (r_state == ST_RUN);
  assign w_int_live = i_int_req & i_eflags_if;
  assign w_done     = w_run & i_rom_ready & i_s1_valid & i_s1_ready;
  assign w_exc_set  = i_exc_req & (i_exc_prog != P_NONE);

  assign o_dec_ready = w_idle & ~i_flush & ~w_exc_pend & ~w_int_live;
  assign w_dec_take  = i_dec_valid & i_dec_ucode_req & (i_dec_ucode_prog != P_NONE) & o_dec_ready;

  ucode_pend_reg #(.W(PROG_W)) u_exc_pend (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_set      (w_exc_set),
    .i_set_data (i_exc_prog),
    .i_clr      (w_exc_clr),
    .o_valid    (w_exc_pend),
    .o_data     (w_exc_pend_prog)
  );

  // A flush in RUN waits for program completion; a flush on the done cycle
  // itself is applied immediately through i_flush below.
  ucode_pend_reg #(.W(PROG_W)) u_flush_pend (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_set      (i_flush & w_run),
    .i_set_data ('0),
    .i_clr      (w_done),
    .o_valid    (w_flush_pend),
    .o_data     (w_flush_unused_data)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cur_prog_nxt = r_cur_prog;
    w_exc_clr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_flush) begin
          w_exc_clr = 1'b1;
        end else if (w_exc_pend) begin
          w_state_nxt    = ST_RUN;
          w_cur_prog_nxt = w_exc_pend_prog;
          w_exc_clr      = 1'b1;
        end else if (w_int_live) begin
          w_state_nxt    = ST_RUN;
          w_cur_prog_nxt = INT_PROG;
        end else if (w_dec_take) begin
          w_state_nxt    = ST_RUN;
          w_cur_prog_nxt = i_dec_ucode_prog;
        end
      end
      ST_RUN: begin
        if (w_done) begin
          w_state_nxt    = ST_IDLE;
          w_cur_prog_nxt = P_NONE;
          // Deferred flush lands now and discards any exception queued behind it.
          w_exc_clr      = w_flush_pend | i_flush;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_cur_prog_nxt = P_NONE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_cur_prog <= P_NONE;
      r_int_ack  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_prog <= w_cur_prog_nxt;
      r_int_ack  <= w_done & (r_cur_prog == INT_PROG);
    end
  end

  assign o_rom_in_control = w_run;
  assign o_rom_control    = r_cur_prog;
  assign o_int_ack        = r_int_ack;

endmodule

// File: tb/tb_ucode_dispatch.sv
// Scoreboard bench for ucode_dispatch: expected program IDs are queued at stimulus
// time and checked whenever microcode ownership rises.
module tb_ucode_dispatch;

  logic       clk;
  logic       reset;
  logic       dec_valid;
  logic       dec_ucode_req;
  logic [3:0] dec_ucode_prog;
  logic       dec_ready;
  logic       exc_req;
  logic [3:0] exc_prog;
  logic       int_req;
  logic       eflags_if;
  logic       flush;
  logic       rom_ready;
  logic       s1_valid;
  logic       s1_ready;
  logic       rom_in_control;
  logic [3:0] rom_control;
  logic       int_ack;

  int n_cmp;
  int n_bad;
  int sb_q[$];
  int cur_exp;
  int exp_ack;
  int obs_ack;
  logic prev_ric;

  ucode_dispatch u_dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_dec_valid      (dec_valid),
    .i_dec_ucode_req  (dec_ucode_req),
    .i_dec_ucode_prog (dec_ucode_prog),
    .o_dec_ready      (dec_ready),
    .i_exc_req        (exc_req),
    .i_exc_prog       (exc_prog),
    .i_int_req        (int_req),
    .i_eflags_if      (eflags_if),
    .i_flush          (flush),
    .i_rom_ready      (rom_ready),
    .i_s1_valid       (s1_valid),
    .i_s1_ready       (s1_ready),
    .o_rom_in_control (rom_in_control),
    .o_rom_control    (rom_control),
    .o_int_ack        (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dec_request(input int prog);
    dec_valid      = 1'b1;
    dec_ucode_req  = 1'b1;
    dec_ucode_prog = 4'(prog);
  endtask

  task automatic dec_clear();
    dec_valid      = 1'b0;
    dec_ucode_req  = 1'b0;
    dec_ucode_prog = 4'd0;
  endtask

  // Feed n micro-ops, one accepted per cycle, rom_ready on the last.
  task automatic finish_prog(input int nops);
    for (int i = 0; i < nops; i++) begin
      s1_valid  = 1'b1;
      s1_ready  = 1'b1;
      rom_ready = (i == nops - 1);
      cyc();
    end
    s1_valid  = 1'b0;
    s1_ready  = 1'b0;
    rom_ready = 1'b0;
  endtask

  // Ownership monitor: rising rom_in_control consumes one scoreboard entry.
  initial begin
    int v;
    prev_ric = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ric = 1'b0;
      end else begin
        if (rom_in_control && !prev_ric) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_dispatch", int'(rom_control), 0);
          end else begin
            v = sb_q.pop_front();
            cur_exp = v;
            chk("dispatch_prog", int'(rom_control), v);
          end
        end else if (rom_in_control) begin
          chk("hold_prog", int'(rom_control), cur_exp);
        end else begin
          chk("idle_prog", int'(rom_control), 0);
        end
        if (int_ack) obs_ack++;
        prev_ric = rom_in_control;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_bad = 0; exp_ack = 0; obs_ack = 0; cur_exp = 0;
    reset = 1'b1;
    dec_clear();
    exc_req = 1'b0; exc_prog = 4'd0;
    int_req = 1'b0; eflags_if = 1'b0; flush = 1'b0;
    rom_ready = 1'b0; s1_valid = 1'b0; s1_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_ric", int'(rom_in_control), 0);
    chk("rst_rc", int'(rom_control), 0);
    chk("rst_ack", int'(int_ack), 0);
    reset = 1'b0;
    cyc();
    chk("rst_dec_ready", int'(dec_ready), 1);

    // Decoder program 8, two micro-ops.
    dec_request(8); sb_q.push_back(8);
    cyc();
    dec_clear();
    chk("s1_ric", int'(rom_in_control), 1);
    chk("s1_rc", int'(rom_control), 8);
    chk("s1_run_dec_ready", int'(dec_ready), 0);
    finish_prog(2);
    chk("s1_rel_ric", int'(rom_in_control), 0);
    chk("s1_rel_rc", int'(rom_control), 0);
    cyc();

    // Interrupt beats decoder program 9.
    int_req = 1'b1; eflags_if = 1'b1; dec_request(9);
    #1 chk("s2_dec_ready", int'(dec_ready), 0);
    sb_q.push_back(6);
    cyc();
    int_req = 1'b0; dec_clear();
    chk("s2_rc", int'(rom_control), 6);
    finish_prog(1);
    exp_ack++;
    chk("s2_ack_hi", int'(int_ack), 1);
    cyc();
    chk("s2_ack_lo", int'(int_ack), 0);

    // Masked interrupt: decoder program 10 runs, no ack.
    int_req = 1'b1; eflags_if = 1'b0; dec_request(10);
    #1 chk("s3_dec_ready", int'(dec_ready), 1);
    sb_q.push_back(10);
    cyc();
    int_req = 1'b0; dec_clear();
    chk("s3_rc", int'(rom_control), 10);
    finish_prog(3);
    chk("s3_ack0", int'(int_ack), 0);
    cyc();
    chk("s3_ack1", int'(int_ack), 0);

    // Exceptions 11 then 12 during program 8: first wins.
    dec_request(8); sb_q.push_back(8);
    cyc();
    dec_clear();
    exc_req = 1'b1; exc_prog = 4'd11; sb_q.push_back(11);
    cyc();
    exc_prog = 4'd12;
    cyc();
    exc_req = 1'b0; exc_prog = 4'd0;
    finish_prog(2);
    chk("s4_gap_ric", int'(rom_in_control), 0);
    cyc();
    chk("s4_exc_ric", int'(rom_in_control), 1);
    chk("s4_exc_rc", int'(rom_control), 11);
    finish_prog(1);
    repeat (3) cyc();
    chk("s4_no12", int'(rom_in_control), 0);

    // Exception on the same cycle as done is still taken.
    dec_request(2); sb_q.push_back(2);
    cyc();
    dec_clear();
    s1_valid = 1'b1; s1_ready = 1'b1; rom_ready = 1'b1;
    exc_req = 1'b1; exc_prog = 4'd13; sb_q.push_back(13);
    cyc();
    s1_valid = 1'b0; s1_ready = 1'b0; rom_ready = 1'b0;
    exc_req = 1'b0; exc_prog = 4'd0;
    chk("s4b_gap", int'(rom_in_control), 0);
    cyc();
    chk("s4b_rc", int'(rom_control), 13);
    finish_prog(1);
    cyc();

    // Flush in RUN of program 1 is deferred and kills the queued exception.
    dec_request(1); sb_q.push_back(1);
    cyc();
    dec_clear();
    exc_req = 1'b1; exc_prog = 4'd11;
    cyc();
    exc_req = 1'b0; exc_prog = 4'd0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    chk("s5_hold_ric", int'(rom_in_control), 1);
    chk("s5_hold_rc", int'(rom_control), 1);
    finish_prog(2);
    repeat (3) cyc();
    chk("s5_no_exc", int'(rom_in_control), 0);
    flush = 1'b1; dec_request(5);
    #1 chk("s5_flush_dec_ready", int'(dec_ready), 0);
    cyc();
    flush = 1'b0; dec_clear();
    chk("s5_flush_block", int'(rom_in_control), 0);
    cyc();

    // Downstream backpressure holds release.
    dec_request(3); sb_q.push_back(3);
    cyc();
    dec_clear();
    rom_ready = 1'b1; s1_valid = 1'b1; s1_ready = 1'b0;
    cyc();
    chk("s6_stall0", int'(rom_in_control), 1);
    cyc();
    chk("s6_stall1", int'(rom_in_control), 1);
    s1_ready = 1'b1;
    cyc();
    rom_ready = 1'b0; s1_valid = 1'b0; s1_ready = 1'b0;
    chk("s6_release", int'(rom_in_control), 0);
    cyc();

    // Reset mid-RUN clears state and the pending exception.
    dec_request(4); sb_q.push_back(4);
    cyc();
    dec_clear();
    exc_req = 1'b1; exc_prog = 4'd12;
    cyc();
    exc_req = 1'b0; exc_prog = 4'd0; reset = 1'b1;
    cyc();
    chk("s7_ric", int'(rom_in_control), 0);
    chk("s7_rc", int'(rom_control), 0);
    chk("s7_ack", int'(int_ack), 0);
    reset = 1'b0;
    #1 chk("s7_dec_ready", int'(dec_ready), 1);
    repeat (3) cyc();
    chk("s7_no_exc", int'(rom_in_control), 0);

    chk("sb_drain", sb_q.size(), 0);
    chk("int_ack_count", obs_ack, exp_ack);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ucode_dispatch.md
# ucode_dispatch

Decode-stage controller upstream of the microcode ROM sequencer. It arbitrates between three sources of microcode requests: pending exceptions, maskable interrupts, and complex instructions flagged by the decoder. It then drives `rom_in_control` and `rom_control[3:0]` to the ROM sequencer, holds the program select stable until the last micro-op is accepted downstream, and stalls the decoder while microcode owns the pipe.

## Interface
- `PROG_W`, default 4: program-select width; must match the ROM sequencer.
- `INT_PROG`, default 4'd6: program ID of the interrupt-entry microcode.
- `clk`  in  1  clock; all state on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `dec_valid`  in  1  decoder has an instruction.
- `dec_ucode_req`  in  1  instruction needs microcode.
- `dec_ucode_prog`  in  4  requested program ID; 0 is reserved and means no request.
- `dec_ready`  out  1  dispatch accepts a decoder microcode request.
- `exc_req`  in  1  one-cycle exception pulse.
- `exc_prog`  in  4  exception program ID, sampled with `exc_req`.
- `int_req`  in  1  level interrupt request.
- `eflags_if`  in  1  interrupt-enable flag.
- `flush`  in  1  one-cycle pipeline flush pulse.
- `rom_ready`  in  1  ROM is on the last micro-op of the program.
- `s1_valid`, `s1_ready`  in  1 each  downstream handshake on ROM output.
- `rom_in_control`  out  1  microcode owns the decode output.
- `rom_control`  out  4  active program ID; 0 when idle.
- `int_ack`  out  1  one-cycle pulse when interrupt-entry microcode completes.

## Operation
- States: IDLE and RUN. Register `cur_prog` holds the active program.
- Pending latches:
  - `exc_pend` and `exc_pend_prog` are set by `exc_req` with a nonzero `exc_prog`. While an exception is already pending, a second `exc_req` is dropped (first wins).
  - `flush_pend` is set by `flush` in RUN.
- In IDLE, the following priorities are evaluated each cycle:
  1. `flush`: clear `exc_pend`; stay in IDLE.
  2. `exc_pend`: go to RUN with `cur_prog=exc_pend_prog`; clear `exc_pend`.
  3. `int_req & eflags_if`: go to RUN with `cur_prog=INT_PROG`.
  4. `dec_valid & dec_ucode_req & dec_ucode_prog!=0 & dec_ready`: go to RUN with `cur_prog=dec_ucode_prog`.
- `dec_ready` = IDLE & ~flush & ~exc_pend & ~(int_req & eflags_if).
- `done` = RUN & `rom_ready` & `s1_valid` & `s1_ready`.
- On `done`: go to IDLE and `cur_prog` goes to 0. If `cur_prog==INT_PROG`, assert `int_ack` the next cycle. Clear `flush_pend`; that flush has now been applied.
- Flush in RUN is deferred, not abortive. The ROM micro-counter only resets at program completion, so `rom_control` never changes mid-program.
- `exc_req` arriving in RUN is latched and taken in the first IDLE cycle after `done`.
- Simultaneous `done` and `exc_req`: the exception is latched. The following IDLE cycle dispatches it.
- `rom_in_control` = RUN. `rom_control` = `cur_prog`. Both are registered outputs.

## Timing
- Reset values: state IDLE, `rom_in_control=0`, `rom_control=0`, `int_ack=0`, all pending flags 0. `dec_ready` is 1 after reset when no other source is active.
- Dispatch latency: acceptance at cycle T gives `rom_in_control=1` and a valid `rom_control` at T+1.
- Release: `done` at cycle T gives `rom_in_control=0` and `rom_control=0` at T+1. `int_ack` is high for T+1 only.
- Minimum gap between programs is one IDLE cycle; back-to-back dispatch without an idle cycle is prohibited.
- `dec_ready` is combinational from registered state plus `flush`, `int_req` and `eflags_if`. There is no path from `dec_valid` to `dec_ready`.
- Reset mid-program clears everything on the next edge. The ROM sequencer resets on the same `reset`.

## Structure
- Shared decode package holds:
  - program ID constants: `PROG_NONE=0`, `INT_PROG=6`, exception IDs;
  - the state encoding;
  - `PROG_W`.
- One sub-module, `ucode_pend_reg`: a 1-bit valid plus 4-bit payload latch with set-if-empty and clear. It is used for the exception latch, and for the flush latch with payload unused.
- Build from the standard cell library and shared register/mux modules, matching the rest of decode.

## Test plan
- Reset released, `dec_valid=1`, `dec_ucode_req=1`, prog 8 at T → `rom_control=8` and `rom_in_control=1` at T+1. With 2 micro-ops accepted (`rom_ready` on the 2nd), `rom_control=0` one cycle later.
- In IDLE, `int_req=1`, `eflags_if=1`, decoder also requesting prog 9 → `INT_PROG` (6) dispatched and `dec_ready=0`. On completion, `int_ack` pulses exactly 1 cycle.
- `int_req=1` with `eflags_if=0` plus decoder prog 10 → program 10 runs; no `int_ack`.
- `exc_req` prog 11 during RUN of program 8, then `exc_req` prog 12 → after 8 completes, one IDLE cycle, then 11 runs. Program 12 is never dispatched.
- `flush` in RUN of program 1 → `rom_control` stays 1 until `done`; no further dispatch occurs from a flushed pending exception.
- `s1_ready=0` while `rom_ready=1` → no release; release one cycle after `s1_ready` rises. `reset` mid-RUN → all outputs 0 next cycle.
